// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address width, default return-stack depth,
// link-stack state encoding and fault codes.
package cpu_pkg;

    localparam int AW          = 10;
    localparam int STACK_DEPTH = 8;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FAULT  = 2'd2
    } ls_state_t;

    localparam logic [1:0] FC_NONE      = 2'b00;
    localparam logic [1:0] FC_OVERFLOW  = 2'b01;
    localparam logic [1:0] FC_UNDERFLOW = 2'b10;

endpackage

// File: rtl/link_stack.sv
// Hardware return-address stack feeding the program counter's return link.
// A call pushes the incremented PC and a return pops it. A call and a return
// in the same cycle replace the top entry (tail call). Overflow and underflow
// freeze the stack in a sticky FAULT state until start.
module link_stack #(
    parameter int DEPTH = cpu_pkg::STACK_DEPTH,
    parameter int AW    = cpu_pkg::AW
) (
    input  logic                       clk,
    input  logic                       start,
    input  logic                       push,
    input  logic                       pop,
    input  logic [AW-1:0]              npc,
    output logic [AW-1:0]              rl,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       empty,
    output logic                       full,
    output logic                       fault,
    output logic [1:0]                 fault_code
);

    import cpu_pkg::*;

    localparam int IW = $clog2(DEPTH);
    localparam int DW = IW + 1;
    localparam logic [DW-1:0] ONE     = DW'(1);
    localparam logic [DW-1:0] MAX_DEP = DW'(DEPTH);

    ls_state_t       state, state_nxt;
    logic [DW-1:0]   depth_nxt;
    logic [1:0]      code_nxt;
    logic            wr_en;
    logic [IW-1:0]   wr_idx;
    logic [IW-1:0]   top_idx;
    logic [AW-1:0]   entry [DEPTH];

    assign empty   = (depth == '0);
    assign full    = (depth == MAX_DEP);
    assign fault   = (state == FAULT);
    assign top_idx = IW'(depth - ONE);

    // Return link comes only from stored state; masked to zero while empty.
    assign rl = empty ? '0 : entry[top_idx];

    // Next-state, pointer and write decode for call/return strobes.
    always_comb begin
        state_nxt = state;
        depth_nxt = depth;
        code_nxt  = fault_code;
        wr_en     = 1'b0;
        wr_idx    = '0;
        case (state)
            EMPTY, ACTIVE: begin
                if (push && pop && !empty) begin
                    wr_en  = 1'b1;
                    wr_idx = top_idx;
                end else if (push) begin
                    if (full) begin
                        state_nxt = FAULT;
                        code_nxt  = FC_OVERFLOW;
                    end else begin
                        wr_en     = 1'b1;
                        wr_idx    = IW'(depth);
                        depth_nxt = depth + ONE;
                        state_nxt = ACTIVE;
                    end
                end else if (pop) begin
                    if (empty) begin
                        state_nxt = FAULT;
                        code_nxt  = FC_UNDERFLOW;
                    end else begin
                        depth_nxt = depth - ONE;
                        state_nxt = (depth == ONE) ? EMPTY : ACTIVE;
                    end
                end
            end
            default: begin
                // FAULT: everything holds until start.
            end
        endcase
    end

    // Control registers; start overrides any strobe.
    always_ff @(posedge clk) begin
        if (start) begin
            state      <= EMPTY;
            depth      <= '0;
            fault_code <= FC_NONE;
        end else begin
            state      <= state_nxt;
            depth      <= depth_nxt;
            fault_code <= code_nxt;
        end
    end

    // Entry storage; not reset, and never written in a start cycle.
    always_ff @(posedge clk) begin
        if (wr_en && !start) begin
            entry[wr_idx] <= npc;
        end
    end

endmodule

// File: tb/tb_link_stack.sv
// Self-checking bench for link_stack: directed scenarios followed by random
// strobes, all compared against a queue-based return-stack model.
module tb_link_stack;

    localparam int DEPTH = 8;
    localparam int AW    = 10;
    localparam int DW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          start = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [AW-1:0] npc = '0;
    logic [AW-1:0] rl;
    logic [DW-1:0] depth;
    logic          empty, full, fault;
    logic [1:0]    fault_code;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int unsigned stk[$];
    bit          m_fault;
    int unsigned m_code;

    link_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .start(start), .push(push), .pop(pop), .npc(npc),
        .rl(rl), .depth(depth), .empty(empty), .full(full),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned m_rl();
        return (stk.size() > 0) ? stk[stk.size()-1] : 0;
    endfunction

    task automatic model_edge(input bit s, input bit pu, input bit po, input int unsigned v);
        if (s) begin
            stk.delete();
            m_fault = 0;
            m_code  = 0;
        end else if (m_fault) begin
        end else if (pu && po && stk.size() > 0) begin
            stk[stk.size()-1] = v;
        end else if (pu) begin
            if (stk.size() == DEPTH) begin
                m_fault = 1;
                m_code  = 1;
            end else begin
                stk.push_back(v);
            end
        end else if (po) begin
            if (stk.size() == 0) begin
                m_fault = 1;
                m_code  = 2;
            end else begin
                void'(stk.pop_back());
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".depth"}, 32'(depth), 32'(stk.size()));
        check({tag, ".rl"}, 32'(rl), m_rl());
        check({tag, ".empty"}, 32'(empty), 32'(stk.size() == 0));
        check({tag, ".full"}, 32'(full), 32'(stk.size() == DEPTH));
        check({tag, ".fault"}, 32'(fault), 32'(m_fault));
        check({tag, ".code"}, 32'(fault_code), m_code);
    endtask

    // Apply one cycle of strobes; rl is checked while the strobe is still
    // applied (it must not depend on this cycle's inputs), then all outputs
    // are checked after the edge.
    task automatic step(input string tag, input bit s, input bit pu, input bit po,
                        input int unsigned v);
        start = s;
        push  = pu;
        pop   = po;
        npc   = AW'(v);
        #1;
        check({tag, ".rl_pre"}, 32'(rl), m_rl());
        @(posedge clk);
        model_edge(s, pu, po, v);
        #1;
        start = 0;
        push  = 0;
        pop   = 0;
        check_all(tag);
    endtask

    initial begin
        stk.delete();
        m_fault = 0;
        m_code  = 0;
        @(posedge clk);
        #1;

        // Reset
        step("rst", 1, 0, 0, 0);

        // Two pushes then a pop
        step("push123", 0, 1, 0, 'h123);
        step("push2a0", 0, 1, 0, 'h2A0);
        check("d2.rl", 32'(rl), 32'h2A0);
        step("pop1", 0, 0, 1, 0);
        check("d1.rl", 32'(rl), 32'h123);

        // Fill to full, then overflow
        step("rst2", 1, 0, 0, 0);
        for (int i = 1; i <= 8; i++) step("fill", 0, 1, 0, i);
        check("full.flag", 32'(full), 32'd1);
        check("full.rl", 32'(rl), 32'h008);
        step("ovf", 0, 1, 0, 'h3FF);
        check("ovf.code", 32'(fault_code), 32'd1);
        check("ovf.rl", 32'(rl), 32'h008);
        check("ovf.depth", 32'(depth), 32'd8);
        step("ovf_pop_ign", 0, 0, 1, 0);

        // Underflow, ignored push, start clears
        step("rst3", 1, 0, 0, 0);
        step("unf", 0, 0, 1, 0);
        check("unf.code", 32'(fault_code), 32'd2);
        step("unf_push_ign", 0, 1, 0, 'h055);
        check("unf.depth", 32'(depth), 32'd0);
        step("unf_clear", 1, 0, 0, 0);
        check("unf.fault", 32'(fault), 32'd0);

        // Tail-call replace, and push+pop from empty
        step("push_a", 0, 1, 0, 'h011);
        step("push_b", 0, 1, 0, 'h022);
        step("push_c", 0, 1, 0, 'h0C0);
        step("tail", 0, 1, 1, 'h1FE);
        check("tail.rl", 32'(rl), 32'h1FE);
        check("tail.depth", 32'(depth), 32'd3);
        step("tail_pop", 0, 0, 1, 0);
        step("rst4", 1, 0, 0, 0);
        step("pp_empty", 0, 1, 1, 'h010);
        check("pp_empty.rl", 32'(rl), 32'h010);

        // Start overriding a push at depth 5
        step("rst5", 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("fill5", 0, 1, 0, 'h100 + i);
        step("start_push", 1, 1, 0, 'h3AA);
        check("start_push.empty", 32'(empty), 32'd1);

        // Random strobes
        for (int i = 0; i < 600; i++) begin
            bit s, pu, po;
            s  = ($urandom_range(0, 39) == 0);
            pu = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 40);
            step("rand", s, pu, po, $urandom_range(0, 1023));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/link_stack.md
LINK_STACK -- requirements
Module: link_stack

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the number of return-address entries (power of two, 2..16).
REQ-002 The block SHALL have parameter AW, default 10, meaning the instruction-address width.
REQ-003 Port clk  input  1  is the single clock; all state updates SHALL occur on its rising edge.
REQ-004 Port start  input  1  is reset: synchronous, active-high.
REQ-005 Port push  input  1  is the subroutine-call strobe (the jump2sub decode).
REQ-006 Port pop  input  1  is the subroutine-return strobe (the retFsub decode).
REQ-007 Port npc  input  AW  is the incremented PC, pushed as the return address.
REQ-008 Port rl  output  AW  is the return link: the top-of-stack entry.
REQ-009 Port depth  output  $clog2(DEPTH)+1  is the current number of valid entries.
REQ-010 Ports empty and full SHALL each be output, 1 bit, giving depth==0 and depth==DEPTH respectively.
REQ-011 Port fault  output  1  is a sticky overflow/underflow indication.
REQ-012 Port fault_code  output  2  SHALL encode 00 none, 01 overflow, 10 underflow.

Function
REQ-013 Storage SHALL be DEPTH registers of AW bits, with a stack pointer equal to depth.
REQ-014 rl SHALL equal entry[depth-1] when depth>0, and 0 when empty.
REQ-015 rl SHALL be driven from registered state only, with no combinational path from push, pop or npc, so it is valid in the same cycle that pop is asserted.
REQ-016 The state machine SHALL have three states: EMPTY, ACTIVE (0<depth<=DEPTH) and FAULT.
REQ-017 Push only, when not full: entry[depth] <= npc and depth <= depth+1 at the next edge.
REQ-018 Pop only, when not empty: depth <= depth-1; entry contents SHALL NOT be cleared.
REQ-019 Push and pop together, when depth>0: entry[depth-1] <= npc and depth SHALL be unchanged (tail-call replace).
REQ-020 Push and pop together, when empty: the block SHALL behave as push only.
REQ-021 Push when full (without pop) SHALL perform no write, leave depth unchanged, enter FAULT and set fault_code=01.
REQ-022 Pop when empty (without push) SHALL leave depth at 0, enter FAULT and set fault_code=10.
REQ-023 In FAULT, push and pop SHALL be ignored, rl, depth and storage SHALL hold, and fault SHALL stay 1 until start.
REQ-024 Transitions: EMPTY->ACTIVE on push; ACTIVE->EMPTY on pop at depth==1 without push; ACTIVE or EMPTY->FAULT per REQ-021/REQ-022; FAULT->EMPTY only on start.
REQ-025 Every operation SHALL take effect in one cycle, with new rl and depth visible in the cycle after the strobe.
REQ-026 Arithmetic: depth SHALL never wrap; indices SHALL be computed modulo nothing, since out-of-range is prevented by REQ-021 and REQ-022.

Reset
REQ-027 While start is 1 at a clock edge, the next state SHALL be EMPTY, with depth=0, rl=0, empty=1, full=0, fault=0 and fault_code=00.
REQ-028 start SHALL override push and pop in the same cycle, including mid-sequence and while in FAULT.
REQ-029 Storage entries SHALL NOT require reset; rl SHALL be masked to 0 while empty.

Structure
REQ-030 AW, the default DEPTH, the state enum (EMPTY/ACTIVE/FAULT) and the fault_code constants SHALL reside in the shared package cpu_pkg.
REQ-031 No sub-module is natural; storage, pointer and FSM SHALL be implemented in one module.
REQ-032 The block SHALL sit upstream of program_counter: rl feeds the PC's rl input, push/pop are the same decodes that drive jump2sub/retFsub, and npc comes from the PC's incrementer.

Verification
REQ-033 The bench SHALL cover: start for one cycle -> depth=0, rl=0, empty=1, fault=0.
REQ-034 The bench SHALL cover: push npc=0x123 then push 0x2A0 -> depth=2, rl=0x2A0; then pop -> depth=1, rl=0x123.
REQ-035 The bench SHALL cover: eight pushes 0x001..0x008 -> full=1, rl=0x008; a ninth push 0x3FF -> fault=1, fault_code=01, rl=0x008, depth=8.
REQ-036 The bench SHALL cover: pop when empty -> fault=1, fault_code=10; then push 0x055 -> ignored, depth=0; then start -> fault=0.
REQ-037 The bench SHALL cover: depth=3 with top 0x0C0, push and pop together with npc=0x1FE -> depth=3, rl=0x1FE; push and pop together when empty with npc=0x010 -> depth=1, rl=0x010.
REQ-038 The bench SHALL cover: start asserted together with push at depth=5 -> depth=0, no write, empty=1.
